tff_updown_counter: RTL and testbench
=====================================

Name: tff_updown_counter

Overview:
- Parametrised synchronous up/down counter built from per-bit toggle logic, WIDTH bits wide, with a programmable modulus.
- Replaces the 3-bit ripple T-flip-flop counter.
- All bits update on one clock edge, so there is no ripple clocking.
- Adds parallel load, direction control, a cascade carry (tc) and a registered wrap pulse so that counters can be chained or used as timers.

Parameters:
- WIDTH, 3, number of count bits. Legal range 1..16.
- MODULUS, 8, count range is 0..MODULUS-1. Legal range 2..2**WIDTH. Violations are reported by $error at elaboration.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- t_in  input  1  count enable (toggle enable); when 1, counter advances one step per clock.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- t_out  output  WIDTH  registered count value.
- tc  output  1  combinational terminal-count / cascade carry.
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Reset: while reset==0, t_out=0 and wrap=0 immediately (asynchronous, no clock needed). tc follows its equation from t_out=0.
- Release: reset deasserts asynchronously. The first count or load takes effect on the first rising clk edge with reset==1.
- Priority at each rising edge: load > t_in count > hold.
- Load:
  - load==1: t_out <= load_val, wrap <= 0. t_in and up_dn are ignored that cycle.
  - If load_val >= MODULUS, t_out <= MODULUS-1 (clamp).
- Count up (t_in==1, up_dn==1, load==0):
  - t_out <= t_out+1.
  - If t_out==MODULUS-1: t_out <= 0 and wrap <= 1.
- Count down (t_in==1, up_dn==0, load==0):
  - t_out <= t_out-1.
  - If t_out==0: t_out <= MODULUS-1 and wrap <= 1.
- Hold (t_in==0, load==0): t_out unchanged, wrap <= 0.
- wrap:
  - High for exactly the one cycle following the wrapping edge.
  - Back-to-back wraps, possible only when MODULUS==2 or on consecutive direction-reversing wraps, keep wrap high on each such cycle.
- tc (combinational, no register):
  - tc = t_in & ~load & (up_dn ? t_out==MODULUS-1 : t_out==0).
  - Drives the next stage's t_in for synchronous cascading on the same clk.
- Latency: t_out reflects load/count one clock after the sampling edge. tc reflects t_out and inputs in the same cycle.
- Direction change mid-count takes effect on the next edge with no extra cycles.
- Arithmetic is modulo MODULUS. t_out never holds a value >= MODULUS.
- Reset asserted mid-operation clears t_out and wrap immediately, regardless of load or t_in.
- When MODULUS==2**WIDTH, the wrap compare reduces to natural binary overflow; behaviour is identical.

Optional Feature:
- Macro: TFF_CNT_SATURATE_EN.
- Defined:
  - Counting past a terminal value holds instead of wrapping: up at MODULUS-1 stays MODULUS-1; down at 0 stays 0.
  - wrap pulses one cycle on each such blocked step, acting as an overflow/underflow indication.
  - tc equation is unchanged.
- Not defined: modulo wrap-around as specified in Behaviour.

Test Plan (WIDTH=3, MODULUS=6 unless noted):
- Reset: reset=0 mid-count at t_out=4 with no clock edge -> t_out=0, wrap=0 immediately. Release with t_in=0 -> t_out stays 0.
- Up wrap: t_in=1, up_dn=1 from 0 for 7 edges -> t_out 1,2,3,4,5,0,1. wrap=1 only in the cycle t_out==0. tc=1 while t_out==5.
- Down wrap: load_val=1 with load, then t_in=1, up_dn=0 for 3 edges -> t_out 1,0,5,4. wrap=1 in the cycle t_out==5. tc=1 while t_out==0.
- Load priority and clamp: load=1, t_in=1, load_val=7 -> t_out=5, wrap=0. Next edge with load=0, up -> t_out=0, wrap=1.
- Cascade: two instances (WIDTH=3, MODULUS=8), stage-1 t_in = stage-0 tc, up, 64 edges -> combined {s1,s0} counts 0..63 and returns to 0. s1 wrap pulses once.
- With TFF_CNT_SATURATE_EN: up from 4 for 3 edges -> t_out 5,5,5. wrap=1 on the 2nd and 3rd cycles.

Source files
------------

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: synchronous modulo-MODULUS up/down counter.
// Each bit is held in a toggle cell that flips when its toggle enable is set.
// All bits update on one clock edge.
// Provides a parallel load, direction control, a combinational cascade carry
// (tc) and a registered wrap pulse.
// Optional build macro TFF_CNT_SATURATE_EN: a count step past a terminal
// value holds the count instead of wrapping. wrap still pulses on that step.
module tff_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             wrap
);

  // Reject parameter values that the design does not support.
  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("tff_updown_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("tff_updown_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic             load_clamp;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] chain_toggle;
  logic [WIDTH-1:0] toggle;

  // Terminal detection and the cascade carry. This is also the wrap condition.
  assign at_max  = (t_out == MAX_VAL);
  assign at_zero = (t_out == '0);
  assign tc      = t_in & ~load & (up_dn ? at_max : at_zero);

  // A loaded value that is out of range is clamped to the top of the count range.
  assign load_clamp = (32'(load_val) >= 32'(MODULUS));
  assign load_eff   = load_clamp ? MAX_VAL : load_val;

  // Binary toggle chain.
  // Counting up, bit i flips when all lower bits are 1.
  // Counting down, bit i flips when all lower bits are 0.
  always_comb begin
    logic [WIDTH-1:0] low_mask;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    chain_toggle = '0;
    low_mask     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (up_dn) chain_toggle[i] = ((t_out & low_mask) == low_mask);
      else       chain_toggle[i] = ((t_out & low_mask) == '0);
      low_mask[i] = 1'b1;
    end
  end

  // Choose the per-bit toggle enables.
  // Load has priority over a count step, and a count step over hold.
  // A terminal step either jumps to the opposite end of the range or, in the
  // saturating build, holds the count.
  always_comb begin
    toggle = '0;
    if (load) begin
      toggle = t_out ^ load_eff;
    end else if (tc) begin
`ifdef TFF_CNT_SATURATE_EN
      toggle = '0;
`else
      toggle = up_dn ? t_out : (t_out ^ MAX_VAL);
`endif
    end else if (t_in) begin
      toggle = chain_toggle;
    end
  end

  // Toggle cells and the wrap pulse register. Reset clears both at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_out <= '0;
      wrap  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      t_out <= t_out ^ toggle;
      wrap  <= tc;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Self-checking bench for tff_updown_counter.
// Runs directed scenarios plus random traffic on a WIDTH=3, MODULUS=6
// instance, checked against an integer reference model.
// Also checks a two-stage cascade of WIDTH=3, MODULUS=8 counters.
`timescale 1ns/1ps
module tb_tff_updown_counter;

  localparam int W   = 3;
  localparam int MOD = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         t_in, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] t_out;
  logic         tc, wrap;

  // cascade pair
  logic         c_en;
  logic [2:0]   c0_q, c1_q;
  logic         c0_tc, c1_tc, c0_wrap, c1_wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_cnt  = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  tff_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .reset(reset), .t_in(t_in), .up_dn(up_dn), .load(load),
    .load_val(load_val), .t_out(t_out), .tc(tc), .wrap(wrap)
  );

  tff_updown_counter #(.WIDTH(3), .MODULUS(8)) u_c0 (
    .clk(clk), .reset(reset), .t_in(c_en), .up_dn(1'b1), .load(1'b0),
    .load_val(3'd0), .t_out(c0_q), .tc(c0_tc), .wrap(c0_wrap)
  );

  tff_updown_counter #(.WIDTH(3), .MODULUS(8)) u_c1 (
    .clk(clk), .reset(reset), .t_in(c0_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(3'd0), .t_out(c1_q), .tc(c1_tc), .wrap(c1_wrap)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock step of the counter rules, using the inputs seen at the edge.
  function automatic void model_edge();
    if (!reset) begin
      m_cnt = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt  = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      m_wrap = 0;
    end else if (t_in) begin
      int nxt;
      nxt    = up_dn ? m_cnt + 1 : m_cnt - 1;
      m_wrap = (nxt < 0 || nxt >= MOD) ? 1 : 0;
`ifdef TFF_CNT_SATURATE_EN
      if (m_wrap == 0) m_cnt = nxt;
`else
      m_cnt  = (nxt + MOD) % MOD;
`endif
    end else begin
      m_wrap = 0;
    end
  endfunction

  function automatic int model_tc();
    if (!t_in || load) return 0;
    return up_dn ? int'(m_cnt == MOD - 1) : int'(m_cnt == 0);
  endfunction

  // Advance one edge, then compare every output with the model.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("t_out", int'(t_out), m_cnt);
    check("wrap",  int'(wrap),  m_wrap);
    check("tc",    int'(tc),    model_tc());
  endtask

  task automatic set_in(input logic ti, input logic ud, input logic ld,
                        input logic [W-1:0] lv);
    t_in = ti; up_dn = ud; load = ld; load_val = lv;
  endtask

  initial begin
    int up_exp   [7];
    int up_wrap  [7];
    int dn_exp   [3];
    int dn_wrap  [3];
    int c1_wraps;

    up_exp  = '{1, 2, 3, 4, 5, 0, 1};
    up_wrap = '{0, 0, 0, 0, 0, 1, 0};
    dn_exp  = '{0, 5, 4};
    dn_wrap = '{0, 1, 0};

    c_en = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, '0);
    reset = 1'b0;
    #1;
    check("reset_t_out", int'(t_out), 0);
    check("reset_wrap",  int'(wrap),  0);
    check("reset_tc_dn", int'(tc),    0);
    #12 reset = 1'b1;

    // Count up through a wrap, with explicit expected values.
    set_in(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin
      tick();
`ifndef TFF_CNT_SATURATE_EN
      check("up_seq",  int'(t_out), up_exp[i]);
      check("up_wrap", int'(wrap),  up_wrap[i]);
      if (up_exp[i] == 5) check("up_tc_at5", int'(tc), 1);
`endif
    end

    // Load 1, then count down through a wrap.
    set_in(1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    check("dn_load", int'(t_out), 1);
    set_in(1'b1, 1'b0, 1'b0, '0);
    check("dn_tc_at1", int'(tc), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
`ifndef TFF_CNT_SATURATE_EN
      check("dn_seq",  int'(t_out), dn_exp[i]);
      check("dn_wrap", int'(wrap),  dn_wrap[i]);
      if (dn_exp[i] == 0) check("dn_tc_at0", int'(tc), 1);
`endif
    end

    // Load takes priority over counting, and out-of-range values are clamped.
    set_in(1'b1, 1'b1, 1'b1, 3'd7);
    check("tc_masked_by_load", int'(tc), 0);
    tick();
    check("clamp_val",  int'(t_out), 5);
    check("clamp_wrap", int'(wrap),  0);
    set_in(1'b1, 1'b1, 1'b0, '0);
    tick();
`ifndef TFF_CNT_SATURATE_EN
    check("post_clamp_val",  int'(t_out), 0);
    check("post_clamp_wrap", int'(wrap),  1);
`endif

`ifdef TFF_CNT_SATURATE_EN
    // In the saturating build, counting up from 4 holds at 5.
    set_in(1'b0, 1'b1, 1'b1, 3'd4);
    tick();
    set_in(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_val",  int'(t_out), 5);
      check("sat_wrap", int'(wrap),  (i == 0) ? 0 : 1);
    end
`endif

    // Asynchronous reset in the middle of a count, with no clock edge needed.
    set_in(1'b0, 1'b1, 1'b1, 3'd4);
    tick();
    set_in(1'b1, 1'b1, 1'b0, '0);
    #3 reset = 1'b0;
    m_cnt = 0; m_wrap = 0;
    #1;
    check("async_rst_t_out", int'(t_out), 0);
    check("async_rst_wrap",  int'(wrap),  0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, '0);
    #3 reset = 1'b1;
    tick();
    check("rst_release_hold", int'(t_out), 0);

    // Random traffic, including occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
             W'($urandom));
      #1;
      check("rnd_tc_pre", int'(tc), model_tc());
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b0;
        m_cnt = 0; m_wrap = 0;
        #1;
        check("rnd_async_rst", int'(t_out), 0);
        #1 reset = 1'b1;
      end
      tick();
    end

`ifndef TFF_CNT_SATURATE_EN
    // Two cascaded stages count 0..63 and return to 0. The upper stage wraps once.
    c1_wraps = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      check("cascade_val", int'({c1_q, c0_q}), i % 64);
      if (c1_wrap) c1_wraps++;
    end
    c_en = 1'b0;
    check("cascade_s1_wraps", c1_wraps, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Stop the run if it ever exceeds its time budget.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
